// File: rtl/ysyx_25060173_mem_arbiter.sv
// ysyx_25060173_mem_arbiter: round-robin IFU/LSU arbiter for one SRAM-style port with a timeout watchdog
module ysyx_25060173_mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_e            state_q;
    logic              owner_q;
    logic              last_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              pick_lsu;
    logic              grant;
    logic              rsp;
    logic              tmo;
    logic              done;
    // owner encoding: 1 = LSU; on conflict the requester that did not go last wins
    always_comb begin
        pick_lsu = lsu_req & (~ifu_req | ~last_q);
        grant    = reset & (state_q == IDLE) & (ifu_req | lsu_req);
        rsp      = (state_q == WAIT) & mem_rvalid;
        tmo      = (TIMEOUT != 0) & (state_q != IDLE) & (cnt_q == TO) & ~rsp;
        done     = rsp | tmo;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    assign ifu_gnt    = grant & ~pick_lsu;
    assign lsu_gnt    = grant & pick_lsu;
    assign ifu_rvalid = done & ~owner_q;
    assign lsu_rvalid = done & owner_q;
    assign ifu_rdata  = (rsp & ~owner_q) ? mem_rdata : 32'd0;
    assign lsu_rdata  = (rsp & owner_q & ~we_q) ? mem_rdata : 32'd0;
    assign err        = tmo;
    assign mem_req    = (state_q == REQ);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wmask  = wmask_q;
    // transaction FSM: capture winner payload, present it, await response or timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (ifu_req | lsu_req) begin
                    owner_q <= pick_lsu;
                    last_q  <= pick_lsu;
                    addr_q  <= pick_lsu ? lsu_addr : ifu_addr;
                    we_q    <= pick_lsu & lsu_we;
                    wdata_q <= pick_lsu ? lsu_wdata : 32'd0;
                    wmask_q <= (pick_lsu & lsu_we) ? lsu_wmask : 4'd0;
                    cnt_q   <= '0;
                    state_q <= REQ;
                end
                REQ: begin
                    cnt_q   <= cnt_d;
                    state_q <= tmo ? IDLE : (mem_ready ? WAIT : REQ);
                end
                WAIT: begin
                    cnt_q   <= cnt_d;
                    state_q <= done ? IDLE : WAIT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// tb_ysyx_25060173_mem_arbiter: transaction-level model check of the memory arbiter with TIMEOUT=4
module tb_ysyx_25060173_mem_arbiter;
    logic        clk = 0;
    logic        reset = 0;
    logic        ifu_req = 0;
    logic [31:0] ifu_addr = 0;
    logic        ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 0, lsu_we = 0;
    logic [31:0] lsu_addr = 0, lsu_wdata = 0;
    logic [3:0]  lsu_wmask = 0;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;
    logic        err;
    int checks = 0;
    int failures = 0;
    int last_own;
    bit pend_i, pend_l;
    int glog[$];

    ysyx_25060173_mem_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One whole transaction: arbitration cycle, REQ phase held d cycles before ready (d=7: never ready),
    // then a response l cycles into WAIT; anything reaching count 4 without a response is a timeout.
    task automatic txn(input string tag, input bit ni, input bit nl, input logic [31:0] ia, input logic [31:0] la,
                       input bit nwe, input logic [31:0] wd, input logic [3:0] wm, input int d, input int l,
                       input logic [31:0] rd, input bit junk);
        bit w, any, ewe, fin, r, t;
        logic [31:0] ea, ewd;
        logic [3:0] ewm;
        logic [5:0] exp_c;
        logic [63:0] exp_d;
        if (ni && !pend_i) begin pend_i = 1; ifu_addr = ia; end
        if (nl && !pend_l) begin pend_l = 1; lsu_addr = la; lsu_we = nwe; lsu_wdata = wd; lsu_wmask = wm; end
        ifu_req = pend_i; lsu_req = pend_l; mem_ready = 0; mem_rvalid = junk; mem_rdata = $urandom;
        #2;
        any = pend_i || pend_l;
        w = pend_l && (!pend_i || last_own == 0);
        exp_c = {pend_i && !w, w, 4'b0000};
        checks++;
        if ({ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, err, mem_req} !== exp_c) begin
            failures++;
            $display("FAIL %s idle gnt/rv/err/req got=%b exp=%b", tag, {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, err, mem_req}, exp_c);
        end
        checks++;
        if ({ifu_rdata, lsu_rdata} !== 64'd0) begin
            failures++;
            $display("FAIL %s idle rdata got=%h exp=0", tag, {ifu_rdata, lsu_rdata});
        end
        step;
        if (!any) begin mem_rvalid = 0; return; end
        last_own = w;
        glog.push_back(w);
        ea = w ? lsu_addr : ifu_addr;
        ewe = w && lsu_we;
        ewm = ewe ? lsu_wmask : 4'd0;
        ewd = lsu_wdata;
        if (w) pend_l = 0; else pend_i = 0;
        ifu_req = pend_i; lsu_req = pend_l;
        fin = 0;
        for (int k = 0; k <= 4; k++) begin
            t = (k == 4);
            mem_ready = (k == d);
            mem_rvalid = junk && !t && ($urandom_range(1) == 1);
            mem_rdata = $urandom;
            #2;
            exp_c = {2'b00, t && !w, t && w, t, 1'b1};
            checks++;
            if ({ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, err, mem_req} !== exp_c) begin
                failures++;
                $display("FAIL %s req k=%0d gnt/rv/err/req got=%b exp=%b", tag, k, {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, err, mem_req}, exp_c);
            end
            checks++;
            if ({mem_addr, mem_we, mem_wmask} !== {ea, ewe, ewm}) begin
                failures++;
                $display("FAIL %s req k=%0d addr/we/mask got=%h/%b/%b exp=%h/%b/%b", tag, k, mem_addr, mem_we, mem_wmask, ea, ewe, ewm);
            end
            checks++;
            if ({ifu_rdata, lsu_rdata} !== 64'd0) begin
                failures++;
                $display("FAIL %s req k=%0d rdata got=%h exp=0", tag, k, {ifu_rdata, lsu_rdata});
            end
            if (ewe) begin
                checks++;
                if (mem_wdata !== ewd) begin
                    failures++;
                    $display("FAIL %s req k=%0d wdata got=%h exp=%h", tag, k, mem_wdata, ewd);
                end
            end
            fin = t;
            step;
            if (fin || k == d) break;
        end
        mem_rvalid = 0;
        for (int j = 0; j <= 4 && !fin; j++) begin
            r = (j == l);
            t = !r && (d + 1 + j == 4);
            mem_ready = 0; mem_rvalid = r; mem_rdata = rd;
            #2;
            exp_c = {2'b00, (r || t) && !w, (r || t) && w, t, 1'b0};
            exp_d = {(r && !w) ? rd : 32'd0, (r && w && !ewe) ? rd : 32'd0};
            checks++;
            if ({ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, err, mem_req} !== exp_c) begin
                failures++;
                $display("FAIL %s wait j=%0d gnt/rv/err/req got=%b exp=%b", tag, j, {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, err, mem_req}, exp_c);
            end
            checks++;
            if ({ifu_rdata, lsu_rdata} !== exp_d) begin
                failures++;
                $display("FAIL %s wait j=%0d rdata got=%h exp=%h", tag, j, {ifu_rdata, lsu_rdata}, exp_d);
            end
            fin = r || t;
            step;
        end
        mem_rvalid = 0; mem_ready = 0;
    endtask

    task automatic test_reset;
        reset = 0; ifu_req = 1; lsu_req = 1; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        step; step;
        checks++;
        if ({ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err} !== '0) begin
            failures++;
            $display("FAIL reset outputs got gnt=%b%b rv=%b%b req=%b err=%b addr=%h", ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_req, err, mem_addr);
        end
        ifu_req = 0; lsu_req = 0; mem_ready = 0; mem_rvalid = 0;
        reset = 1; last_own = 1; pend_i = 0; pend_l = 0;
        step;
    endtask

    task automatic test_conflict;
        int exp_order[5] = '{0, 1, 0, 1, 0};
        glog.delete();
        for (int i = 0; i < 4; i++)
            txn("conflict", 1, 1, $urandom, $urandom, $urandom_range(1) == 1, $urandom, 4'($urandom), $urandom_range(2), $urandom_range(1), $urandom, 0);
        txn("conflict_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (glog.size() <= i || glog[i] != exp_order[i]) begin
                failures++;
                $display("FAIL conflict_order idx=%0d got=%0d exp=%0d", i, glog.size() > i ? glog[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_ifu_only;
        txn("ifu_only", 1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 32'h0010_0093, 0);
    endtask

    task automatic test_store;
        txn("store", 0, 1, 0, 32'h8000_1000, 1, 32'hCAFE_BABE, 4'b0011, 3, 0, 32'h5555_AAAA, 0);
    endtask

    task automatic test_timeout;
        txn("timeout_wait", 1, 0, 32'h8000_0040, 0, 0, 0, 0, 0, 9, 32'h1111_2222, 0);
        txn("late_rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        txn("timeout_req", 0, 1, 0, 32'h8000_2000, 0, 0, 4'hF, 7, 0, 32'h3333_4444, 0);
        txn("late_rvalid2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_precedence;
        txn("precedence", 1, 0, 32'h8000_0080, 0, 0, 0, 0, 0, 3, 32'h0BAD_F00D, 0);
    endtask

    task automatic test_reset_in_wait;
        ifu_req = 1; lsu_req = 0; ifu_addr = 32'h8000_0100;
        step;
        ifu_req = 0; mem_ready = 1;
        step;
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678; ifu_req = 1; lsu_req = 1;
        #1;
        checks++;
        if ({ifu_rvalid, ifu_rdata} !== {1'b1, 32'h1234_5678}) begin
            failures++;
            $display("FAIL rst_wait pre rv/rdata got=%b/%h exp=1/12345678", ifu_rvalid, ifu_rdata);
        end
        reset = 0;
        #1;
        checks++;
        if ({ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err} !== '0) begin
            failures++;
            $display("FAIL rst_wait async outputs got gnt=%b%b rv=%b%b req=%b err=%b rdata=%h", ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_req, err, ifu_rdata);
        end
        step; step;
        reset = 1; ifu_req = 0; lsu_req = 0; mem_rvalid = 0;
        pend_i = 0; pend_l = 0; last_own = 1;
        glog.delete();
        txn("rst_conflict", 1, 1, 32'h8000_0200, 32'h8000_3000, 0, 0, 0, 0, 0, 32'h7777_8888, 0);
        checks++;
        if (glog.size() != 1 || glog[0] != 0) begin
            failures++;
            $display("FAIL rst_first_winner got=%0d exp=0", glog.size() > 0 ? glog[0] : -1);
        end
        txn("rst_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 200; i++)
            txn("random", $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom, $urandom, $urandom_range(1) == 1,
                $urandom, 4'($urandom), ($urandom_range(7) == 0) ? 7 : $urandom_range(3), $urandom_range(5), $urandom,
                $urandom_range(1) == 1);
        txn("random_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom, 0);
        txn("random_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom, 0);
    endtask

    initial begin
        test_reset;
        test_conflict;
        test_ifu_only;
        test_store;
        test_timeout;
        test_precedence;
        test_reset_in_wait;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
